// File: rtl/bp_pkg.sv
// bp_pkg: shared types, counter encodings and saturating helpers for the branch predictor.
//   Holds the default geometry (32-bit PC, 64 entries) that sizes btb_entry_t.
package bp_pkg;
  localparam int BP_XLEN = 32;
  localparam int BP_ENTRIES = 64;
  localparam int BP_IDX_W = $clog2(BP_ENTRIES);
  localparam int BP_TAG_W = BP_XLEN - BP_IDX_W - 2;
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT = 2'b10;
  localparam logic [1:0] ST = 2'b11;
  typedef struct packed {
    logic valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_XLEN-1:0] target;
  } btb_entry_t;
  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == ST) ? ST : c + 2'd1;
  endfunction
  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction
endpackage

// File: rtl/bp_sat_counter_table.sv
// bp_sat_counter_table: ENTRIES x 2-bit saturating counters, one async read port, one write port.
//   clk, rst_n      : clock, async active-low reset (all counters -> WNT)
//   rd_idx, rd_cnt  : combinational read of the current (pre-update) counter
//   wr_en, wr_idx   : write strobe and index
//   wr_alloc        : load WT (new allocation) instead of stepping the counter
//   wr_up           : step direction when not allocating (1 = increment, 0 = decrement)
module bp_sat_counter_table
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_cnt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_alloc,
  input  logic             wr_up
);
  logic [1:0] cnt_q [ENTRIES];
  logic [1:0] cnt_d [ENTRIES];
  assign rd_cnt = cnt_q[rd_idx];
  always_comb begin
    cnt_d = cnt_q;
    if (wr_en) cnt_d[wr_idx] = wr_alloc ? WT : wr_up ? sat_inc(cnt_q[wr_idx]) : sat_dec(cnt_q[wr_idx]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '{default: WNT};
    else cnt_q <= cnt_d;
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: fetch-side bimodal predictor with a tagged, direct-mapped target buffer.
//   Optional global-history (gshare) counter indexing when BRANCH_PREDICTOR_GSHARE_EN is defined.
//   clk, rst_n                          : clock, async active-low reset
//   fetch_valid, fetch_pc               : lookup request
//   pred_valid, pred_taken, pred_target : registered prediction, one cycle after the lookup
//   upd_valid, upd_pc, upd_taken, upd_target : resolved-branch training input
//   pred_hist / upd_hist (gshare only)  : history used for a lookup, returned with its update
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ENTRIES = 64,
  localparam int IDX_W = $clog2(ENTRIES),
  localparam int TAG_W = XLEN - IDX_W - 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_valid,
  input  logic [XLEN-1:0]  fetch_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
`ifdef BRANCH_PREDICTOR_GSHARE_EN
  output logic [IDX_W-1:0] pred_hist,
  input  logic [IDX_W-1:0] upd_hist,
`endif
  input  logic             upd_valid,
  input  logic [XLEN-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic [XLEN-1:0]  upd_target
);
  // btb_entry_t is sized from the package geometry, so the parameters must agree with it.
  if (XLEN != BP_XLEN || TAG_W != BP_TAG_W) begin : g_geom_check
    $error("branch_predictor: XLEN/ENTRIES must match bp_pkg geometry");
  end
  btb_entry_t btb_q [ENTRIES];
  btb_entry_t btb_d [ENTRIES];
  logic [IDX_W-1:0] f_idx, u_idx, rd_idx, wr_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic f_hit, u_hit;
  logic [1:0] rd_cnt;
  logic pred_valid_q, pred_valid_d, pred_taken_q, pred_taken_d;
  logic [XLEN-1:0] pred_target_q, pred_target_d;
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{fetch_pc[1:0], upd_pc[1:0]};
  assign f_idx = fetch_pc[IDX_W+1:2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign f_tag = fetch_pc[XLEN-1:IDX_W+2];
  assign u_tag = upd_pc[XLEN-1:IDX_W+2];
  assign f_hit = btb_q[f_idx].valid && (btb_q[f_idx].tag == f_tag);
  assign u_hit = btb_q[u_idx].valid && (btb_q[u_idx].tag == u_tag);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [IDX_W-1:0] hist_q, hist_d, pred_hist_q, pred_hist_d;
  assign rd_idx = f_idx ^ hist_q;
  assign wr_idx = u_idx ^ upd_hist;
  assign pred_hist = pred_hist_q;
  always_comb begin
    hist_d = upd_valid ? {hist_q[IDX_W-2:0], upd_taken} : hist_q;
    pred_hist_d = fetch_valid ? hist_q : pred_hist_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hist_q <= '0;
      pred_hist_q <= '0;
    end else begin
      hist_q <= hist_d;
      pred_hist_q <= pred_hist_d;
    end
`else
  assign rd_idx = f_idx;
  assign wr_idx = u_idx;
`endif
  bp_sat_counter_table #(.ENTRIES(ENTRIES)) u_cnt (
    .clk(clk),
    .rst_n(rst_n),
    .rd_idx(rd_idx),
    .rd_cnt(rd_cnt),
    .wr_en(upd_valid && (u_hit || upd_taken)),
    .wr_idx(wr_idx),
    .wr_alloc(!u_hit),
    .wr_up(upd_taken)
  );
  // Any taken resolution writes the full entry: on a hit only the target changes,
  // on a miss it allocates and evicts the previous occupant.
  always_comb begin
    btb_d = btb_q;
    if (upd_valid && upd_taken) btb_d[u_idx] = '{valid: 1'b1, tag: u_tag, target: upd_target};
    pred_valid_d = fetch_valid;
    pred_taken_d = fetch_valid ? (f_hit && rd_cnt[1]) : pred_taken_q;
    pred_target_d = !fetch_valid ? pred_target_q : pred_taken_d ? btb_q[f_idx].target : fetch_pc + XLEN'(4);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      btb_q <= '{default: '0};
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_target_q <= '0;
    end else begin
      btb_q <= btb_d;
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_target_q <= pred_target_d;
    end
  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign pred_target = pred_target_q;
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side branch predictor. It is the predicting end of the branch path; the execute-stage Branch comparator is the resolving end.
- Lookup: fetch presents a PC, and one cycle later the block returns a taken/not-taken guess and a target. The guess comes from a direct-mapped table of 2-bit saturating counters plus a tagged target buffer.
- Update: execute feeds each resolved outcome back (the Branch out_valid result plus the computed target) to train the table.

Parameters:
- XLEN, 32, PC/target width.
- ENTRIES, 64, table depth; power of two, at least 4.
- IDX_W, $clog2(ENTRIES), index width (derived, not overridable).
- TAG_W, XLEN-IDX_W-2, tag width (derived).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_valid  in  1  lookup request this cycle.
- fetch_pc  in  XLEN  PC to predict; bits [1:0] ignored.
- pred_valid  out  1  prediction valid; registered, one cycle after fetch_valid.
- pred_taken  out  1  predicted taken.
- pred_target  out  XLEN  predicted next PC.
- upd_valid  in  1  a resolved branch is presented this cycle.
- upd_pc  in  XLEN  PC of the resolved branch.
- upd_taken  in  1  actual outcome (Branch out_valid).
- upd_target  in  XLEN  actual taken target.
- pred_hist  out  IDX_W  history snapshot for the prediction (GSHARE_EN builds only).
- upd_hist  in  IDX_W  snapshot returned with the update (GSHARE_EN builds only).

Behaviour:
- Index = pc[IDX_W+1:2]. Tag = pc[XLEN-1:IDX_W+2].
- Per-entry state: valid bit, tag, target, 2-bit counter.
  - Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Reset (async, rst_n=0):
  - All valid bits cleared; all counters = 01.
  - pred_valid=0, pred_taken=0, pred_target=0, history=0.
  - Tags and targets need not be reset.
  - Reset asserted mid-operation discards any in-flight lookup; pred_valid is 0 on the first edge after deassertion.
- Lookup:
  - fetch_valid=1 at edge N gives pred_valid=1 at N+1. hit = valid & tag match.
  - pred_taken = hit & counter[1].
  - pred_target = the stored target if pred_taken, else fetch_pc+4 (wraps modulo 2^XLEN).
  - fetch_valid=0 gives pred_valid=0; pred_taken and pred_target hold their last values.
- Update, on an edge with upd_valid=1:
  - Hit & taken: counter saturating increment; target overwritten with upd_target.
  - Hit & not-taken: counter saturating decrement; target kept.
  - Miss & taken: allocate the entry (valid=1, new tag, target=upd_target, counter=10); any previous occupant is replaced.
  - Miss & not-taken: no change.
- Simultaneous lookup and update at the same index in the same cycle:
  - The lookup sees the pre-update state (read-before-write).
  - The update takes effect for lookups issued from the next cycle.
- Lookup and update never stall; there is no backpressure.

Optional Feature:
- Macro: BRANCH_PREDICTOR_GSHARE_EN.
- When defined:
  - An IDX_W global history register shifts left on every upd_valid, inserting upd_taken; reset value 0.
  - Counter index = pc index XOR history. The target buffer remains PC-indexed.
  - pred_hist returns the history used for the lookup; the pipeline carries it and returns it as upd_hist.
  - Counter updates index with upd_pc index XOR upd_hist.
- When undefined: no history register, pred_hist and upd_hist are absent, and counters are PC-indexed as above.

Decomposition:
- Shared package bp_pkg holds:
  - counter encoding constants (SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11);
  - the counter saturating increment/decrement functions;
  - the btb_entry_t struct {valid, tag, target}.
- One sub-module is natural: bp_sat_counter_table (ENTRIES x 2-bit, one read port, one write port, async reset to WNT).
- Tag and target storage stays in the top level.

Test Plan (ENTRIES=64):
- Reset, then lookup at 0x100 -> next cycle pred_valid=1, pred_taken=0, pred_target=0x104.
- Update 0x100 taken, target 0x80; lookup 0x100 -> pred_taken=1, pred_target=0x80; counter=10.
- Two not-taken updates at 0x100 -> counter 00; lookup -> pred_taken=0, pred_target=0x104. Five taken updates then one not-taken -> counter 10 (saturated at 11 first); pred_taken=1.
- Alias: with 0x100 trained taken, lookup 0x200 (same index 0, different tag) -> miss, pred_target=0x204. Taken update at 0x200, target 0x40 -> lookup 0x100 now misses; lookup 0x200 -> pred_target=0x40.
- Same-cycle fetch 0x100 and update 0x100 taken on an empty table -> prediction not-taken; a lookup the following cycle -> taken.
- rst_n pulsed low mid-lookup -> pred_valid drops immediately; the table is cleared and 0x100 predicts not-taken afterwards.
- GSHARE_EN build: train 0x100 with alternating outcomes, updates carrying upd_hist from the matching pred_hist -> predictions correct after warm-up.
